// File: rtl/affine_addr_gen_if.sv
// affine_addr_gen_if: config/start and address-stream signals of the affine address generator.
// Optional cfg_base field is present when ADDR_GEN_BASE_OFFSET_EN is defined.
interface affine_addr_gen_if #(
    parameter int DIMS  = 3,
    parameter int WIDTH = 16
);
    logic                  start;
    logic [DIMS*WIDTH-1:0] cfg_extent;
    logic [DIMS*WIDTH-1:0] cfg_stride;
`ifdef ADDR_GEN_BASE_OFFSET_EN
    logic [WIDTH-1:0]      cfg_base;
`endif
    logic                  addr_valid;
    logic                  addr_ready;
    logic [WIDTH-1:0]      addr;
    logic                  addr_last;
    logic                  busy;
    logic                  done;

    // Generator side: takes config and ready, produces the address stream.
    modport master (
        input  start, cfg_extent, cfg_stride, addr_ready,
`ifdef ADDR_GEN_BASE_OFFSET_EN
        input  cfg_base,
`endif
        output addr_valid, addr, addr_last, busy, done
    );

    // Controller/consumer side.
    modport slave (
        output start, cfg_extent, cfg_stride, addr_ready,
`ifdef ADDR_GEN_BASE_OFFSET_EN
        output cfg_base,
`endif
        input  addr_valid, addr, addr_last, busy, done
    );
endinterface

// File: rtl/affine_addr_gen.sv
// affine_addr_gen: N-dimensional affine address generator (nested odometer, incremental offsets).
// Define ADDR_GEN_BASE_OFFSET_EN to add a latched cfg_base added to every address.
module affine_addr_gen #(
    parameter int DIMS  = 3,
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    affine_addr_gen_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] max_q [DIMS];
    logic [WIDTH-1:0] max_d [DIMS];
    logic [WIDTH-1:0] str_q [DIMS];
    logic [WIDTH-1:0] str_d [DIMS];
    logic [WIDTH-1:0] idx_q [DIMS];
    logic [WIDTH-1:0] idx_d [DIMS];
    logic [WIDTH-1:0] off_q [DIMS];
    logic [WIDTH-1:0] off_d [DIMS];
    logic [WIDTH-1:0] base_q, base_d, addr_q, addr_d, sum, base_in;
    logic             last_q, last_d, done_q, done_d, carry;

`ifdef ADDR_GEN_BASE_OFFSET_EN
    assign base_in = bus.cfg_base;
`else
    assign base_in = '0;
`endif

    // Next-state: latch config on start, step the odometer on each accepted address.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        str_d   = str_q;
        idx_d   = idx_q;
        off_d   = off_q;
        base_d  = base_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = 1'b0;
        carry   = 1'b1;
        sum     = '0;
        if (state_q == IDLE && bus.start) begin
            state_d = RUN;
            base_d  = base_in;
            addr_d  = base_in;
            last_d  = 1'b1;
            for (int d = 0; d < DIMS; d++) begin
                // Extent 0 behaves like extent 1: the index never leaves 0.
                max_d[d] = (bus.cfg_extent[d*WIDTH +: WIDTH] == '0) ? '0
                         : bus.cfg_extent[d*WIDTH +: WIDTH] - WIDTH'(1);
                str_d[d] = bus.cfg_stride[d*WIDTH +: WIDTH];
                idx_d[d] = '0;
                off_d[d] = '0;
                last_d   = last_d && (max_d[d] == '0);
            end
        end else if (state_q == RUN && bus.addr_ready) begin
            if (last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                last_d  = 1'b0;
            end else begin
                for (int d = 0; d < DIMS; d++) begin
                    if (carry) begin
                        idx_d[d] = (idx_q[d] == max_q[d]) ? '0 : idx_q[d] + WIDTH'(1);
                        off_d[d] = (idx_q[d] == max_q[d]) ? '0 : off_q[d] + str_q[d];
                    end
                    carry = carry && (idx_q[d] == max_q[d]);
                end
                sum    = base_q;
                last_d = 1'b1;
                for (int d = 0; d < DIMS; d++) begin
                    sum    = sum + off_d[d];
                    last_d = last_d && (idx_d[d] == max_d[d]);
                end
                addr_d = sum;
            end
        end
    end

    // State and datapath registers; async reset returns to an idle, all-zero walker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int d = 0; d < DIMS; d++) begin
                max_q[d] <= '0;
                str_q[d] <= '0;
                idx_q[d] <= '0;
                off_q[d] <= '0;
            end
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
            max_q   <= max_d;
            str_q   <= str_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.addr_last  = last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_affine_addr_gen.sv
// tb_affine_addr_gen: table-driven scoreboard bench for affine_addr_gen (DIMS=3, WIDTH=16).
module tb_affine_addr_gen;
    localparam int DIMS  = 3;
    localparam int WIDTH = 16;

    typedef struct {
        logic [47:0] ext;
        logic [47:0] stride;
        logic [15:0] base;
        int          mode;
        bit          mid_start;
        bit          chain;
        int          len;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    vec_t tbl[10];

    affine_addr_gen_if #(.DIMS(DIMS), .WIDTH(WIDTH)) bus();
    affine_addr_gen #(.DIMS(DIMS), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives start there, returns at the done negedge (or one later if !chain).
    task automatic run_walk(input vec_t v);
        int          e[3];
        int          n;
        int          cyc;
        bit          fin;
        logic [15:0] b;
        logic [15:0] a;
        exp_t        x;
        n = 0;
        cyc = 0;
        fin = 1'b0;
`ifdef ADDR_GEN_BASE_OFFSET_EN
        b = v.base;
`else
        b = 16'h0;
`endif
        for (int d = 0; d < 3; d++)
            e[d] = (v.ext[d*16 +: 16] == 16'h0) ? 1 : int'(v.ext[d*16 +: 16]);
        q.delete();
        for (int i2 = 0; i2 < e[2]; i2++)
            for (int i1 = 0; i1 < e[1]; i1++)
                for (int i0 = 0; i0 < e[0]; i0++) begin
                    a = b + 16'(i0) * v.stride[15:0] + 16'(i1) * v.stride[31:16]
                          + 16'(i2) * v.stride[47:32];
                    x.addr = a;
                    x.last = (i0 == e[0] - 1) && (i1 == e[1] - 1) && (i2 == e[2] - 1);
                    q.push_back(x);
                end
        bus.start = 1'b1;
        bus.cfg_extent = v.ext;
        bus.cfg_stride = v.stride;
`ifdef ADDR_GEN_BASE_OFFSET_EN
        bus.cfg_base = v.base;
`endif
        bus.addr_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!fin && cyc < 1000) begin
            bus.addr_ready = (v.mode == 0) ? 1'b1
                           : (v.mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                           : 1'($urandom_range(0, 1));
            if (v.mid_start) begin
                bus.start = (cyc == 3);
                if (cyc == 3) begin
                    bus.cfg_extent = '1;
                    bus.cfg_stride = '1;
                end
            end
            check("valid", bus.addr_valid, 1);
            check("busy", bus.busy, 1);
            check("done_early", bus.done, 0);
            x = q[0];
            check("addr", bus.addr, x.addr);
            check("last", bus.addr_last, x.last);
            if (bus.addr_ready) begin
                void'(q.pop_front());
                n++;
                fin = x.last;
            end
            cyc++;
            @(negedge clk);
        end
        bus.addr_ready = 1'b0;
        bus.start = 1'b0;
        check("timeout", fin, 1);
        check("count", n, v.len);
        check("done", bus.done, 1);
        check("valid_after", bus.addr_valid, 0);
        check("busy_after", bus.busy, 0);
        if (!v.chain) begin
            @(negedge clk);
            check("done_width", bus.done, 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.addr_ready = 1'b0;
        bus.cfg_extent = '0;
        bus.cfg_stride = '0;
`ifdef ADDR_GEN_BASE_OFFSET_EN
        bus.cfg_base = '0;
`endif
        tbl[0] = '{48'h0001_0003_0004, 48'h0000_0010_0001, 16'h0000, 0, 1'b0, 1'b0, 12};
        tbl[1] = '{48'h0001_0003_0004, 48'h0000_0010_0001, 16'h0000, 1, 1'b0, 1'b0, 12};
        tbl[2] = '{48'h0001_0000_0001, 48'h0009_0007_0005, 16'h0000, 0, 1'b0, 1'b0, 1};
        tbl[3] = '{48'h0000_0000_0000, 48'h0009_0007_0005, 16'h0000, 0, 1'b0, 1'b0, 1};
        tbl[4] = '{48'h0001_0001_0003, 48'h0000_0000_8000, 16'h0000, 0, 1'b0, 1'b0, 3};
        tbl[5] = '{48'h0002_0003_0005, 48'h0064_0007_0003, 16'hfff0, 2, 1'b0, 1'b0, 30};
        tbl[6] = '{48'h0001_0003_0004, 48'h0000_0010_0001, 16'h0000, 0, 1'b1, 1'b0, 12};
        tbl[7] = '{48'h0002_0002_0002, 48'h0100_0010_0001, 16'h0000, 0, 1'b0, 1'b1, 8};
        tbl[8] = '{48'h0001_0001_0002, 48'h0000_0000_fff0, 16'h0000, 1, 1'b0, 1'b0, 2};
        tbl[9] = '{48'h0001_0003_0004, 48'h0000_0010_0001, 16'h1000, 0, 1'b0, 1'b0, 12};
        repeat (3) @(negedge clk);
        check("rst_addr", bus.addr, 0);
        check("rst_valid", bus.addr_valid, 0);
        check("rst_last", bus.addr_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) run_walk(tbl[i]);
        bus.start = 1'b1;
        bus.cfg_extent = tbl[0].ext;
        bus.cfg_stride = tbl[0].stride;
        bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid", bus.addr_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.addr_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_addr", bus.addr, 0);
        check("arst_last", bus.addr_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid", bus.addr_valid, 0);
            check("post_rst_done", bus.done, 0);
        end
        bus.addr_ready = 1'b0;
        run_walk(tbl[1]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
